// File: rtl/reg_bank_dump_reader_pkg.sv
// Shared constants and FSM state type for the register-bank dump reader.
package reg_bank_dump_reader_pkg;

  localparam int unsigned NumRegs        = 16;
  localparam int unsigned AddrW          = 4;
  localparam int unsigned DataW          = 32;
  localparam int unsigned DefReadLatency = 1;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StSend0,
    StSend1,
    StDone
  } state_e;

endpackage

// File: rtl/reg_bank_dump_reader_if.sv
// Bank read port plus output word stream; master is the dump reader, slave is bank + consumer.
interface reg_bank_dump_reader_if;
  import reg_bank_dump_reader_pkg::*;

  logic [AddrW-1:0] rs1;
  logic [AddrW-1:0] rs2;
  logic [DataW-1:0] data1;
  logic [DataW-1:0] data2;
  logic [DataW-1:0] out_data;
  logic [AddrW-1:0] out_idx;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output rs1, rs2, out_data, out_idx, out_valid, out_last,
    input  data1, data2, out_ready
  );

  modport slave (
    input  rs1, rs2, out_data, out_idx, out_valid, out_last,
    output data1, data2, out_ready
  );

endinterface

// File: rtl/reg_dump_out_stage.sv
// Holds the captured register pair and drives the registered valid/ready output word.
module reg_dump_out_stage
  import reg_bank_dump_reader_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture_i,
  input  logic [DataW-1:0] data1_i,
  input  logic [DataW-1:0] data2_i,
  input  logic             show_a_i,
  input  logic             show_b_i,
  input  logic [AddrW-1:0] pair_i,
  output logic [DataW-1:0] out_data_o,
  output logic [AddrW-1:0] out_idx_o,
  output logic             out_valid_o,
  output logic             out_last_o
);

  logic [DataW-1:0] hold_a_q, hold_b_q;
  logic [DataW-1:0] out_data_q, out_data_d;
  logic [AddrW-1:0] out_idx_q, out_idx_d;
  logic             out_valid_q;
  logic             out_last_q, out_last_d;

  // Staying in a send state re-selects the same hold register, so a stalled word is stable.
  always_comb begin
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    out_last_d = 1'b0;
    if (show_a_i) begin
      out_data_d = capture_i ? data1_i : hold_a_q;
      out_idx_d  = pair_i;
    end else if (show_b_i) begin
      out_data_d = hold_b_q;
      out_idx_d  = pair_i + AddrW'(1);
      out_last_d = (pair_i == AddrW'(NumRegs - 2));
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      hold_a_q    <= '0;
      hold_b_q    <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      if (capture_i) begin
        hold_a_q <= data1_i;
        hold_b_q <= data2_i;
      end
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= show_a_i | show_b_i;
      out_last_q  <= out_last_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_idx_o   = out_idx_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;

endmodule

// File: rtl/reg_bank_dump_reader.sv
// Walks the register bank in even/odd pairs through both read ports and streams
// every register out as an indexed word.
module reg_bank_dump_reader
  import reg_bank_dump_reader_pkg::*;
#(
  parameter int unsigned ReadLatency = DefReadLatency
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic                          abort_i,
  reg_bank_dump_reader_if.master        bus_io,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int unsigned WaitW = (ReadLatency > 1) ? $clog2(ReadLatency) : 1;

  state_e           state_q, state_d;
  logic [AddrW-1:0] pair_q, pair_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [AddrW-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic             busy_q, done_q;
  logic             capture;

  always_comb begin
    state_d = state_q;
    pair_d  = pair_q;
    wait_d  = wait_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          state_d = StIssue;
          pair_d  = '0;
        end
      end
      StIssue: begin
        state_d = StWait;
        wait_d  = WaitW'(ReadLatency - 1);
      end
      StWait: begin
        if (wait_q == '0) begin
          capture = 1'b1;
          state_d = StSend0;
        end else begin
          wait_d = wait_q - WaitW'(1);
        end
      end
      StSend0: begin
        if (bus_io.out_ready) state_d = StSend1;
      end
      StSend1: begin
        if (bus_io.out_ready) begin
          if (pair_q == AddrW'(NumRegs - 2)) begin
            state_d = StDone;
          end else begin
            pair_d  = pair_q + AddrW'(2);
            state_d = StIssue;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort wins even over a handshake in the same cycle.
    if (abort_i && (state_q != StIdle)) begin
      state_d = StIdle;
      capture = 1'b0;
    end
  end

  // Read addresses only move on entry to ISSUE, so they stay put for the whole pair.
  always_comb begin
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    if (state_d == StIssue) begin
      rs1_d = pair_d;
      rs2_d = pair_d + AddrW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= StIdle;
      pair_q  <= '0;
      wait_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      wait_q  <= wait_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StDone);
    end
  end

  reg_dump_out_stage u_out_stage (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture_i  (capture),
    .data1_i    (bus_io.data1),
    .data2_i    (bus_io.data2),
    .show_a_i   (state_d == StSend0),
    .show_b_i   (state_d == StSend1),
    .pair_i     (pair_q),
    .out_data_o (bus_io.out_data),
    .out_idx_o  (bus_io.out_idx),
    .out_valid_o(bus_io.out_valid),
    .out_last_o (bus_io.out_last)
  );

  assign bus_io.rs1 = rs1_q;
  assign bus_io.rs2 = rs2_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_reg_bank_dump_reader.sv
// Directed and random-backpressure checks of the dump reader against a bank/stream model.
module tb_reg_bank_dump_reader;
  import reg_bank_dump_reader_pkg::*;

  typedef struct packed {
    logic [AddrW-1:0] idx;
    logic [DataW-1:0] data;
    logic             last;
  } word_t;

  logic clk         = 1'b0;
  logic rst_n       = 1'b1;
  logic start_i     = 1'b0;
  logic abort_i     = 1'b0;
  logic ready_force = 1'b1;
  logic rand_mode   = 1'b0;
  logic rand_bit    = 1'b0;
  logic busy_o, done_o;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  logic [DataW-1:0] regs [NumRegs];
  word_t            got[$];

  reg_bank_dump_reader_if bus ();

  reg_bank_dump_reader #(.ReadLatency(1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(start_i),
    .abort_i(abort_i),
    .bus_io (bus),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  always #5 clk = ~clk;

  // Bank with one cycle of registered read latency.
  always @(posedge clk) begin
    bus.data1 <= regs[bus.rs1];
    bus.data2 <= regs[bus.rs2];
  end

  assign bus.out_ready = rand_mode ? rand_bit : ready_force;

  always @(negedge clk) begin
    #1;
    rand_bit = 1'($urandom_range(0, 1));
  end

  // Inputs settle at negedge+1; sampling at negedge+2 sees what the next posedge will see.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      if (bus.out_valid && bus.out_ready) got.push_back({bus.out_idx, bus.out_data, bus.out_last});
      if (done_o) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet_outs(input string tag);
    chk({tag, "_rs1"},   bus.rs1, 0);
    chk({tag, "_rs2"},   bus.rs2, 0);
    chk({tag, "_data"},  bus.out_data, 0);
    chk({tag, "_idx"},   bus.out_idx, 0);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_last"},  bus.out_last, 0);
    chk({tag, "_busy"},  busy_o, 0);
    chk({tag, "_done"},  done_o, 0);
  endtask

  task automatic bank_write(input int idx, input logic [DataW-1:0] val);
    if (idx != 0) regs[idx] = val;
  endtask

  // Expected stream: every register once, in index order, last flag on the top index.
  task automatic verify_scan(input string tag, input int base, input int dbase);
    chk({tag, "_count"}, got.size() - base, NumRegs);
    for (int i = 0; i < NumRegs; i++) begin
      word_t exp_w;
      exp_w = {AddrW'(i), regs[i], 1'(i == NumRegs - 1)};
      if (base + i < got.size()) chk($sformatf("%s_w%0d", tag, i), got[base + i], exp_w);
    end
    chk({tag, "_ndone"}, done_cnt - dbase, 1);
  endtask

  // mode 0 plain, 1 stall idx 3 for 5 cycles, 2 stray start at cycle 10. Caller sits at a negedge.
  task automatic do_scan(input string tag, input int mode, input int exp_done, input int exp_idle,
                         input int budget);
    int base, dbase, cyc, dc, ic;
    base  = got.size();
    dbase = done_cnt;
    dc    = -1;
    ic    = -1;
    #1 start_i = 1'b1;
    @(negedge clk);
    #1 start_i = 1'b0;
    cyc = 1;
    chk({tag, "_busy1"}, busy_o, 1);
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (done_o && dc < 0) dc = cyc;
      if (!busy_o) begin
        ic = cyc;
        break;
      end
      if (mode == 1 && cyc >= 8 && cyc <= 12) begin
        chk($sformatf("%s_stall_valid_c%0d", tag, cyc), bus.out_valid, 1);
        chk($sformatf("%s_stall_data_c%0d", tag, cyc), bus.out_data, regs[3]);
        chk($sformatf("%s_stall_idx_c%0d", tag, cyc), bus.out_idx, 3);
        #1 ready_force = 1'b0;
      end else if (mode == 1 && cyc == 13) begin
        #1 ready_force = 1'b1;
      end else if (mode == 2 && cyc == 10) begin
        #1 start_i = 1'b1;
      end else if (mode == 2 && cyc == 11) begin
        #1 start_i = 1'b0;
      end
    end
    if (exp_done > 0) begin
      chk({tag, "_done_cyc"}, dc, exp_done);
      chk({tag, "_idle_cyc"}, ic, exp_idle);
    end else begin
      chk({tag, "_ended"}, (ic > 0), 1);
    end
    verify_scan(tag, base, dbase);
  endtask

  initial begin
    int base, dbase;
    for (int i = 0; i < NumRegs; i++) regs[i] = '0;
    regs[2] = 32'd2;
    regs[3] = 32'd349;

    repeat (2) @(negedge clk);
    chk_quiet_outs("reset");
    #1 rst_n = 1'b0;
    @(negedge clk);

    do_scan("scan_basic", 0, 33, 34, 200);
    if (got.size() >= 16) chk("basic_r3_value", got[got.size() - 13].data, 32'd349);

    do_scan("scan_midstart", 2, 33, 34, 200);
    do_scan("scan_stall", 1, 38, 39, 200);

    bank_write(13, 32'hDEAD_BEEF);
    bank_write(0, 32'h0000_1234);
    do_scan("scan_r13", 0, 33, 34, 200);
    if (got.size() >= 16) begin
      chk("r13_value", got[got.size() - 3].data, 32'hDEAD_BEEF);
      chk("r0_value", got[got.size() - 16].data, 0);
    end

    // Abort in the WAIT cycle of pair 6 (cycle 14).
    base  = got.size();
    dbase = done_cnt;
    #1 start_i = 1'b1;
    @(negedge clk);
    #1 start_i = 1'b0;
    repeat (13) @(negedge clk);
    chk("abort_rs1", bus.rs1, 6);
    chk("abort_wait_valid", bus.out_valid, 0);
    chk("abort_words_before", got.size() - base, 6);
    #1 abort_i = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy_o, 0);
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_done", done_o, 0);
    #1 abort_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt - dbase, 0);
    chk("abort_stay_idle", busy_o, 0);

    #1 begin
      abort_i = 1'b1;
      start_i = 1'b1;
    end
    @(negedge clk);
    chk("abort_start_idle", busy_o, 0);
    #1 begin
      abort_i = 1'b0;
      start_i = 1'b0;
    end
    @(negedge clk);
    do_scan("scan_after_abort", 0, 33, 34, 200);

    // Asynchronous reset in SEND1 of pair 0 (cycle 4).
    base  = got.size();
    dbase = done_cnt;
    #1 start_i = 1'b1;
    @(negedge clk);
    #1 start_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("send1_idx", bus.out_idx, 1);
    chk("send1_valid", bus.out_valid, 1);
    #1 rst_n = 1'b1;
    #1 chk_quiet_outs("async_rst");
    @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_no_resume_busy", busy_o, 0);
    chk("rst_no_resume_valid", bus.out_valid, 0);
    chk("rst_no_done", done_cnt - dbase, 0);
    chk("rst_words_before", got.size() - base, 1);
    do_scan("scan_after_rst", 0, 33, 34, 200);

    rand_mode = 1'b1;
    for (int s = 0; s < 10; s++) begin
      do_scan($sformatf("scan_rand%0d", s), 0, -1, -1, 600);
    end
    rand_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_bank_dump_reader.md
Name: reg_bank_dump_reader

Overview:
Read-side initiator for the 16x32 register bank. On a start pulse it walks all registers in pairs through the bank's two read ports (rs1/rs2 -> data1/data2). It emits each register as one 32-bit word, tagged with its index, on a valid/ready stream to the debug/display path. Sits between the register bank read ports and the debug output logic; the bank is only ever read, never written.

Parameters:
NUM_REGS, 16, registers scanned; must be even, >= 2
ADDR_W, 4, register index width
DATA_W, 32, register data width
READ_LATENCY, 1, WAIT cycles between driving rs1/rs2 and sampling data1/data2; >= 1

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-high (despite the name)
start  in  1  begin a full scan; sampled only in IDLE
abort  in  1  terminate an in-progress scan
rs1  out  ADDR_W  bank read address A (even index)
rs2  out  ADDR_W  bank read address B (odd index)
data1  in  DATA_W  bank read data A
data2  in  DATA_W  bank read data B
out_data  out  DATA_W  register value
out_idx  out  ADDR_W  index of out_data
out_valid  out  1  word available
out_ready  in  1  consumer accepts word
out_last  out  1  out_data is register NUM_REGS-1
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after last word accepted

Behaviour:
- Reset (async, rst_n=1): state=IDLE, pair index=0, wait counter=0, hold regs=0. Outputs rs1=0, rs2=0, out_data=0, out_idx=0, out_valid=0, out_last=0, busy=0, done=0. Reset mid-scan aborts immediately; no done.
- All outputs are registered. rs1/rs2 stay stable from ISSUE until the next ISSUE.
- FSM states: IDLE, ISSUE, WAIT, SEND0, SEND1, DONE.
- IDLE: start=1 -> ISSUE, pair index p=0.
- ISSUE (1 cycle): rs1=p, rs2=p+1 -> WAIT; wait counter loads READ_LATENCY-1.
- WAIT: count down. On the edge leaving the last WAIT cycle, capture data1->holdA and data2->holdB; -> SEND0.
- SEND0: out_valid=1, out_data=holdA, out_idx=p. On out_valid&out_ready -> SEND1.
- SEND1: out_valid=1, out_data=holdB, out_idx=p+1, out_last=(p+1==NUM_REGS-1). On handshake: if p==NUM_REGS-2 -> DONE, else p+=2 -> ISSUE.
- DONE: done=1 for exactly one cycle, busy still 1 -> IDLE.
- Handshake rules: out_data, out_idx and out_last are held stable while out_valid=1 and out_ready=0. out_valid is never dropped without a handshake, except on abort or reset. out_ready is ignored when out_valid=0.
- start while busy: ignored, not queued.
- abort in any non-IDLE state -> IDLE next cycle; out_valid=0, no done pulse.
- abort coinciding with a handshake: the word counts as transferred, and abort still wins, so the scan ends.
- abort and start together in IDLE: abort wins, stay IDLE.
- Timing with out_ready=1 and READ_LATENCY=1: start high at edge 0 -> ISSUE cycle 1, WAIT cycle 2, SEND0 cycle 3, SEND1 cycle 4, next ISSUE cycle 5. Each pair takes 3+READ_LATENCY cycles. Word 15 is in cycle 32, done in cycle 33, IDLE in cycle 34.
- Index arithmetic is unsigned ADDR_W bits; p+1 never wraps because NUM_REGS is even.

Decomposition:
- Shared package: DATA_W/ADDR_W/NUM_REGS constants and the FSM state enum.
- One sub-module: reg_dump_out_stage, the holding register plus valid/ready output register (SEND0/SEND1 mux and hold logic).
- The FSM, pair counter and wait counter stay in the top module.

Test Plan:
- Bank at reset values (r2=2, r3=349, rest 0), out_ready=1, start pulse at cycle 0 -> 16 words idx 0..15 with values 0,0,2,349,0..0. out_last only on idx 15. done pulse in cycle 33, busy low in cycle 34.
- Write r13=0xDEADBEEF before the scan -> word idx 13 = 0xDEADBEEF, and r0 still reads 0.
- Backpressure: out_ready held 0 for 5 cycles during the idx 3 word -> out_valid/out_data=349/out_idx=3 held stable all 5 cycles. No word is lost or duplicated, and done slips by exactly 5 cycles.
- Random out_ready (50%) over 10 full scans -> each scan delivers exactly 16 ordered words and exactly one done.
- abort asserted while in WAIT of pair p=6 -> IDLE next cycle, out_valid=0, no done. A new start then rescans from idx 0.
- start pulsed at cycle 10 mid-scan -> ignored, word sequence unchanged. rst_n asserted during SEND1 -> all outputs 0 asynchronously, and the scan resumes only on a fresh start.
